dmem_access_ctrl: RTL and testbench

//  Sequences all accesses to the word-addressed data memory and arbitrates it between two requesters.
//  - Port 0: pipeline load/store unit. Port 1: debug/program-loader.
//  - Converts byte-addressed byte/half/word loads and stores into whole-word memory reads and writes.
//  - Sub-word stores use read-modify-write. Misaligned and out-of-range accesses are faulted.
//  - Sits between the MEM stage / loader and the data memory.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_lane_align.sv | 37 +++
 rtl/dmem_access_ctrl.sv | 160 ++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory access controller.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } size_e;

   typedef enum logic [2:0] {
      IDLE,
      ACC,
      RD_WAIT,
      WR,
      RESP
   } state_e;

   localparam logic [1:0] SZ_ILLEGAL = 2'b11;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_addr_lo,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load,
   output logic [31:0] o_merged
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte   = i_word[{i_addr_lo, 3'b000} +: 8];
      w_half   = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
      o_load   = i_word;
      o_merged = i_wdata;
      case (i_size)
         SZ_B: begin
            o_load   = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            o_merged = i_word;
            o_merged[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
         end
         SZ_H: begin
            o_load   = {{16{~i_unsigned & w_half[15]}}, w_half};
            o_merged = i_word;
            o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Two-port data-memory access controller: arbitration, sub-word RMW, fault checks.
// state   | meaning
// IDLE    | waiting for a request; combinational grant
// ACC     | check latched request, issue read or word write
// RD_WAIT | capture read word, extract load or merge store lane
// WR      | write back merged word of a sub-word store
// RESP    | pulse rvalid with result/fault to the owning port
module dmem_access_ctrl
   import dmem_pkg::*;
#(
   parameter int NUM_WORDS  = 1024,
   parameter int ADDR_W     = $clog2(NUM_WORDS),
   parameter bit PRIO_FIXED = 1'b0
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [1:0]        p0_size,
   input  logic              p0_unsigned,
   input  logic [31:0]       p0_addr,
   input  logic [31:0]       p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [31:0]       p0_rdata,
   output logic              p0_fault,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [1:0]        p1_size,
   input  logic              p1_unsigned,
   input  logic [31:0]       p1_addr,
   input  logic [31:0]       p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [31:0]       p1_rdata,
   output logic              p1_fault,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   state_e      r_state, w_next;
   logic        r_we, r_uns, r_port, r_last_grant, r_fault;
   logic [1:0]  r_size;
   logic [31:0] r_addr, r_wdata, r_word, r_result;
   logic        w_grant, w_win, w_fault, w_resp;
   logic        w_mem_rd, w_mem_wr, w_rvalid;
   logic [31:0] w_mem_wdata, w_load, w_merged;

   always_comb begin
      w_win = p1_req;
      if (p0_req && p1_req)
         w_win = PRIO_FIXED ? 1'b0 : ~r_last_grant;
   end

   assign w_grant = (r_state == IDLE) && !rst && (p0_req || p1_req);

   assign w_fault = (r_size == SZ_ILLEGAL)
                 || (r_size == SZ_H && r_addr[0])
                 || (r_size == SZ_W && r_addr[1:0] != 2'b00)
                 || (r_addr[31:2] >= 30'(NUM_WORDS));

   dmem_lane_align u_align (
      .i_word     (mem_rdata),
      .i_addr_lo  (r_addr[1:0]),
      .i_size     (r_size),
      .i_unsigned (r_uns),
      .i_wdata    (r_wdata),
      .o_load     (w_load),
      .o_merged   (w_merged)
   );

   always_comb begin
      w_next      = r_state;
      w_mem_rd    = 1'b0;
      w_mem_wr    = 1'b0;
      w_mem_wdata = '0;
      w_rvalid    = 1'b0;
      case (r_state)
         IDLE: if (w_grant) w_next = ACC;
         ACC: begin
            if (w_fault) begin
               w_next = RESP;
            end else if (r_we && r_size == SZ_W) begin
               w_mem_wr    = 1'b1;
               w_mem_wdata = r_wdata;
               w_next      = RESP;
            end else begin
               w_mem_rd = 1'b1;
               w_next   = RD_WAIT;
            end
         end
         RD_WAIT: w_next = r_we ? WR : RESP;
         WR: begin
            w_mem_wr    = 1'b1;
            w_mem_wdata = r_word;
            w_next      = RESP;
         end
         RESP: begin
            w_rvalid = 1'b1;
            w_next   = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_we         <= 1'b0;
         r_uns        <= 1'b0;
         r_port       <= 1'b0;
         r_last_grant <= 1'b1;
         r_fault      <= 1'b0;
         r_size       <= 2'b00;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_word       <= '0;
         r_result     <= '0;
      end else begin
         r_state <= w_next;
         if (w_grant) begin
            r_we         <= w_win ? p1_we       : p0_we;
            r_size       <= w_win ? p1_size     : p0_size;
            r_uns        <= w_win ? p1_unsigned : p0_unsigned;
            r_addr       <= w_win ? p1_addr     : p0_addr;
            r_wdata      <= w_win ? p1_wdata    : p0_wdata;
            r_port       <= w_win;
            r_last_grant <= w_win;
            r_fault      <= 1'b0;
            r_result     <= '0;
         end
         if (r_state == ACC && w_fault)
            r_fault <= 1'b1;
         if (r_state == RD_WAIT) begin
            if (r_we) r_word   <= w_merged;
            else      r_result <= w_load;
         end
      end
   end

   // Gating with rst keeps a reset cycle from committing a pending write.
   assign mem_rd    = w_mem_rd & ~rst;
   assign mem_wr    = w_mem_wr & ~rst;
   assign mem_addr  = (mem_rd | mem_wr) ? r_addr[ADDR_W+1:2] : '0;
   assign mem_wdata = mem_wr ? w_mem_wdata : '0;

   assign w_resp    = w_rvalid & ~rst;
   assign p0_gnt    = w_grant & ~w_win;
   assign p1_gnt    = w_grant & w_win;
   assign p0_rvalid = w_resp & ~r_port;
   assign p1_rvalid = w_resp & r_port;
   assign p0_rdata  = p0_rvalid ? r_result : '0;
   assign p1_rdata  = p1_rvalid ? r_result : '0;
   assign p0_fault  = p0_rvalid & r_fault;
   assign p1_fault  = p1_rvalid & r_fault;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench with an expected-response queue and an independent monitor.
module tb_dmem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        p0_req = 0, p0_we = 0, p0_unsigned = 0;
   logic [1:0]  p0_size = 0;
   logic [31:0] p0_addr = 0, p0_wdata = 0;
   logic        p1_req = 0, p1_we = 0, p1_unsigned = 0;
   logic [1:0]  p1_size = 0;
   logic [31:0] p1_addr = 0, p1_wdata = 0;
   logic        p0_gnt, p0_rvalid, p0_fault, p1_gnt, p1_rvalid, p1_fault;
   logic [31:0] p0_rdata, p1_rdata;
   logic        mem_rd, mem_wr;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   logic        f_p0_gnt, f_p0_rvalid, f_p0_fault, f_p1_gnt, f_p1_rvalid, f_p1_fault;
   logic [31:0] f_p0_rdata, f_p1_rdata, f_mem_wdata;
   logic        f_mem_rd, f_mem_wr;
   logic [9:0]  f_mem_addr;
   logic [31:0] f_mem_rdata = 32'h0;

   always #5 clk = ~clk;

   dmem_access_ctrl #(.NUM_WORDS(1024), .PRIO_FIXED(1'b0)) u_dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_unsigned(p0_unsigned),
      .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
      .p0_rdata(p0_rdata), .p0_fault(p0_fault),
      .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_unsigned(p1_unsigned),
      .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
      .p1_rdata(p1_rdata), .p1_fault(p1_fault),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   dmem_access_ctrl #(.NUM_WORDS(1024), .PRIO_FIXED(1'b1)) u_fix (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_unsigned(p0_unsigned),
      .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(f_p0_gnt), .p0_rvalid(f_p0_rvalid),
      .p0_rdata(f_p0_rdata), .p0_fault(f_p0_fault),
      .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_unsigned(p1_unsigned),
      .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(f_p1_gnt), .p1_rvalid(f_p1_rvalid),
      .p1_rdata(f_p1_rdata), .p1_fault(f_p1_fault),
      .mem_rd(f_mem_rd), .mem_wr(f_mem_wr), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
      .mem_rdata(f_mem_rdata)
   );

   // Memory model with registered read data
   logic [31:0] mem [0:1023];
   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= mem[mem_addr];
      if (mem_wr) mem[mem_addr] <= mem_wdata;
   end

   typedef struct {
      logic        port;
      logic [31:0] rdata;
      logic        fault;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   logic gnt_log[$];
   logic fix_log[$];
   int   n_checks = 0, n_err = 0;
   int   cyc = 0, gnt_cyc = 0, rd_lat = -1, wr_lat = -1, n_wr = 0, n_mem = 0;
   logic [9:0] wr_addr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic outs_nonzero();
      return p0_gnt | p0_rvalid | p0_fault | (|p0_rdata) | p1_gnt | p1_rvalid | p1_fault |
             (|p1_rdata) | mem_rd | mem_wr | (|mem_addr) | (|mem_wdata);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (p0_gnt || p1_gnt) begin
            gnt_cyc = cyc;
            gnt_log.push_back(p1_gnt);
         end
         if (f_p0_gnt || f_p1_gnt) fix_log.push_back(f_p1_gnt);
         if (mem_rd) rd_lat = cyc - gnt_cyc;
         if (mem_wr) begin
            wr_lat  = cyc - gnt_cyc;
            wr_addr = mem_addr;
            n_wr++;
         end
         if (mem_rd || mem_wr) n_mem++;
         else chk("idle_bus_zero", {31'b0, (|mem_addr) | (|mem_wdata)}, 32'h0);
         if (p0_rvalid || p1_rvalid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_rvalid: actual p0=%0b p1=%0b required none", p0_rvalid, p1_rvalid);
            end else begin
               e = exp_q.pop_front();
               chk("rv_port", {31'b0, p1_rvalid}, {31'b0, e.port});
               chk("rv_both", {31'b0, p0_rvalid & p1_rvalid}, 32'h0);
               chk("rdata", e.port ? p1_rdata : p0_rdata, e.rdata);
               chk("fault", {31'b0, e.port ? p1_fault : p0_fault}, {31'b0, e.fault});
               chk("other_port_zero", e.port ? (p0_rdata | {31'b0, p0_fault})
                                             : (p1_rdata | {31'b0, p1_fault}), 32'h0);
               chk("latency", 32'(cyc - gnt_cyc), 32'(e.lat));
            end
         end
      end
   end

   task automatic drive(input bit port, input bit req, input bit we, input logic [1:0] size,
                        input bit uns, input logic [31:0] addr, input logic [31:0] wdata);
      if (port) begin
         p1_req = req; p1_we = we; p1_size = size; p1_unsigned = uns; p1_addr = addr; p1_wdata = wdata;
      end else begin
         p0_req = req; p0_we = we; p0_size = size; p0_unsigned = uns; p0_addr = addr; p0_wdata = wdata;
      end
   endtask

   task automatic wait_gnt(input bit port);
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = port ? p1_gnt : p0_gnt;
      end
      if (!got) begin
         n_checks++;
         n_err++;
         $display("FAIL gnt_timeout: actual no grant on port %0d required grant", port);
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         n_err++;
         $display("FAIL done_timeout: actual pending=%0d required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic issue(input bit port, input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata_exp, input bit fault_exp, input int lat);
      exp_t e;
      e.port = port; e.rdata = rdata_exp; e.fault = fault_exp; e.lat = lat;
      exp_q.push_back(e);
      @(posedge clk); #1;
      drive(port, 1'b1, we, size, uns, addr, wdata);
      wait_gnt(port);
      @(posedge clk); #1;
      drive(port, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      wait_done();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   wr0, mem0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_outputs", {31'b0, outs_nonzero()}, 32'h0);

      // word store then load
      issue(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2);
      chk("sw_wr_cycle", 32'(wr_lat), 32'd1);
      chk("sw_wr_addr", {22'b0, wr_addr}, 32'd4);
      chk("sw_mem", mem[4], 32'hDEADBEEF);
      issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3);
      chk("lw_rd_cycle", 32'(rd_lat), 32'd1);

      // byte store RMW and byte loads
      issue(1, 1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0, 0, 2);
      issue(0, 1, 2'b00, 0, 32'h11, 32'h123456AA, 32'h0, 0, 4);
      chk("sb_rd_cycle", 32'(rd_lat), 32'd1);
      chk("sb_wr_cycle", 32'(wr_lat), 32'd3);
      chk("sb_mem", mem[4], 32'h1122AA44);
      issue(0, 0, 2'b00, 0, 32'h11, 32'h0, 32'hFFFFFFAA, 0, 3);
      issue(1, 0, 2'b00, 1, 32'h11, 32'h0, 32'h000000AA, 0, 3);

      // half loads
      issue(0, 1, 2'b10, 0, 32'h10, 32'h80011234, 32'h0, 0, 2);
      issue(0, 0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFF8001, 0, 3);
      issue(1, 0, 2'b01, 1, 32'h12, 32'h0, 32'h00008001, 0, 3);
      issue(0, 0, 2'b01, 0, 32'h10, 32'h0, 32'h00001234, 0, 3);
      issue(0, 0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFF80, 0, 3);

      // faults: misaligned word, misaligned half, out of range, illegal size
      mem0 = n_mem;
      issue(0, 0, 2'b10, 0, 32'h12,   32'h0, 32'h0, 1, 2);
      issue(1, 1, 2'b01, 0, 32'h13,   32'hFFFF, 32'h0, 1, 2);
      issue(0, 0, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 1, 2);
      issue(1, 0, 2'b11, 0, 32'h10,   32'h0, 32'h0, 1, 2);
      chk("fault_no_mem_ops", 32'(n_mem), 32'(mem0));

      // reset while the sub-word store sits in RD_WAIT
      wr0 = n_wr;
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055);
      wait_gnt(0);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_outputs", {31'b0, outs_nonzero()}, 32'h0);
      repeat (5) @(negedge clk);
      chk("reset_no_wr", 32'(n_wr), 32'(wr0));
      chk("reset_mem_kept", mem[4], 32'h80011234);

      // contention: round-robin starts with p0 after reset, fixed priority always p0
      for (int i = 0; i < 4; i++) begin
         e.port = 1'(i % 2); e.rdata = 32'h80011234; e.fault = 0; e.lat = 3;
         exp_q.push_back(e);
      end
      gnt_log.delete();
      fix_log.delete();
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      for (int i = 0; i < 60 && gnt_log.size() < 4; i++) @(negedge clk);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      wait_done();
      chk("rr_gnt_count", 32'(gnt_log.size()), 32'd4);
      chk("fix_gnt_count", 32'(fix_log.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("rr_order", (i < gnt_log.size()) ? {31'b0, gnt_log[i]} : 32'hF, 32'(i % 2));
         chk("fix_order", (i < fix_log.size()) ? {31'b0, fix_log[i]} : 32'hF, 32'h0);
      end

      // normal service after the dropped transaction
      issue(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h80011234, 0, 3);

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
